// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   - default address / instruction widths
//   - 3-bit FSM state encoding used by fetch_unit
package fetch_unit_pkg;

   localparam int DEF_ADDR_WIDTH  = 8;
   localparam int DEF_INSTR_WIDTH = 8;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_FETCH  = 3'd1;
   localparam state_t S_WAIT   = 3'd2;
   localparam state_t S_LOAD   = 3'd3;
   localparam state_t S_EXEC   = 3'd4;
   localparam state_t S_HALTED = 3'd5;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register.
//   clk_i      : clock, rising edge
//   rst_n_i    : synchronous active-low reset, clears the count
//   inc_i      : add one (wraps modulo 2^ADDR_WIDTH)
//   load_i     : load load_val_i; wins over inc_i
//   load_val_i : parallel load value
//   pc_o       : current count
module pc_counter
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  inc_i,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] load_val_i,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   localparam logic [ADDR_WIDTH-1:0] ONE = 1;

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i)     pc_d = load_val_i;
      else if (inc_i) pc_d = pc_q + ONE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) pc_q <= '0;
      else          pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer.
// Walks IDLE -> FETCH -> WAIT -> LOAD -> EXEC, then back to FETCH when the
// execute stage reports completion (optionally jumping), or to HALTED.
//   CLK, RST_N     : clock, synchronous active-low reset
//   ROM_ADDR       : program ROM address (registered)
//   ROM_DATA       : ROM read data, captured at the end of WAIT
//   INSTR, IR_CE   : fetched word and one-cycle capture enable (LOAD only)
//   EXEC_DONE      : execute-stage completion pulse, only honoured in EXEC
//   JUMP/JUMP_ADDR : redirect PC on completion
//   HALT           : stop on completion; beats JUMP
//   PC, HALTED     : program counter and halted flag
// All outputs come straight from flops.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   output logic [ADDR_WIDTH-1:0]  ROM_ADDR,
   input  logic [INSTR_WIDTH-1:0] ROM_DATA,
   output logic [INSTR_WIDTH-1:0] INSTR,
   output logic                   IR_CE,
   input  logic                   EXEC_DONE,
   input  logic                   JUMP,
   input  logic [ADDR_WIDTH-1:0]  JUMP_ADDR,
   input  logic                   HALT,
   output logic [ADDR_WIDTH-1:0]  PC,
   output logic                   HALTED
);

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                   ir_ce_q, ir_ce_d;
   logic                   halted_q, halted_d;
   logic                   pc_inc, pc_load;
   logic [ADDR_WIDTH-1:0]  pc;

   pc_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc (
      .clk_i      (CLK),
      .rst_n_i    (RST_N),
      .inc_i      (pc_inc),
      .load_i     (pc_load),
      .load_val_i (JUMP_ADDR),
      .pc_o       (pc)
   );

   // state register
   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = S_WAIT;
         S_WAIT:   state_d = S_LOAD;
         S_LOAD:   state_d = S_EXEC;
         S_EXEC:   if (EXEC_DONE) state_d = HALT ? S_HALTED : S_FETCH;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   // outputs: next values for the output flops plus PC control.
   // IR_CE/HALTED are decoded from state_d so the flop holds them
   // exactly while the FSM sits in LOAD/HALTED.
   always_comb begin
      rom_addr_d = rom_addr_q;
      instr_d    = instr_q;
      ir_ce_d    = (state_d == S_LOAD);
      halted_d   = (state_d == S_HALTED);
      pc_inc     = (state_q == S_LOAD);
      pc_load    = (state_q == S_EXEC) && EXEC_DONE && !HALT && JUMP;
      if (state_q == S_FETCH) rom_addr_d = pc;
      if (state_q == S_WAIT)  instr_d    = ROM_DATA;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rom_addr_q <= '0;
         instr_q    <= '0;
         ir_ce_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         instr_q    <= instr_d;
         ir_ce_q    <= ir_ce_d;
         halted_q   <= halted_d;
      end
   end

   assign ROM_ADDR = rom_addr_q;
   assign INSTR    = instr_q;
   assign IR_CE    = ir_ce_q;
   assign HALTED   = halted_q;
   assign PC       = pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the microprocessor core. It holds the program counter, addresses the synchronous program ROM, and presents each fetched word with a one-cycle capture enable to the downstream instruction register. It then waits for the execute stage to finish before fetching again, and applies jumps and halts reported by the execute stage.

## Interface
Parameters:
- ADDR_WIDTH, 8, program counter and ROM address width
- INSTR_WIDTH, 8, instruction word width (equals the instruction register WIDTH)

Ports:
- CLK  in  1  single system clock; all state changes on its rising edge
- RST_N  in  1  synchronous, active-low reset, sampled on the rising edge of CLK
- ROM_ADDR  out  ADDR_WIDTH  program ROM address
- ROM_DATA  in  INSTR_WIDTH  ROM read data, valid one cycle after address is sampled
- INSTR  out  INSTR_WIDTH  fetched word, drives instruction register IN
- IR_CE  out  1  capture enable, drives instruction register CE
- EXEC_DONE  in  1  one-cycle pulse from execute stage: current instruction finished
- JUMP  in  1  qualified by EXEC_DONE: load JUMP_ADDR into PC
- JUMP_ADDR  in  ADDR_WIDTH  jump target
- HALT  in  1  qualified by EXEC_DONE: stop fetching
- PC  out  ADDR_WIDTH  current program counter
- HALTED  out  1  high while in HALTED state

## Operation
- States: IDLE, FETCH, WAIT, LOAD, EXEC, HALTED.
- Reset (RST_N=0 at an edge), from any state: state=IDLE, PC=0, ROM_ADDR=0, INSTR=0, IR_CE=0, HALTED=0.
- IDLE -> FETCH unconditionally on the first edge with RST_N=1.
- FETCH: ROM_ADDR=PC (registered). Next state is WAIT.
- WAIT: ROM returns data. At the end of WAIT, INSTR<=ROM_DATA. Next state is LOAD.
- LOAD: IR_CE=1 for exactly this cycle, with INSTR stable. PC<=PC+1, modulo 2^ADDR_WIDTH, so all-ones wraps to 0. Next state is EXEC.
- EXEC: hold. On EXEC_DONE=1:
  - HALT=1 -> HALTED. PC is unchanged and JUMP is ignored; HALT has priority.
  - else JUMP=1 -> PC<=JUMP_ADDR, then FETCH.
  - else -> FETCH with the incremented PC.
- EXEC_DONE, JUMP and HALT are ignored in every state other than EXEC.
- HALTED: terminal. HALTED=1, IR_CE=0, PC frozen. Only reset leaves it.
- IR_CE is 0 in every state except LOAD.

## Timing
- Fetch latency: FETCH at cycle t, WAIT at t+1, LOAD at t+2. The instruction register holds the new word from t+3.
- Minimum instruction period is 4 cycles (EXEC_DONE in the first EXEC cycle).
- A jump target is visible on ROM_ADDR 2 cycles after the EXEC_DONE edge: FETCH in the next cycle, registered address one cycle later.
- Reset asserted mid-fetch (WAIT or LOAD) suppresses any IR_CE pulse from the next edge onward. A partially fetched word is discarded.
- Every output is driven from a register. There is no combinational path from an input to an output.

## Structure
- A shared package holds:
  - the state encoding: 3-bit localparams S_IDLE..S_HALTED
  - default ADDR_WIDTH and INSTR_WIDTH
- One sub-module, pc_counter: ADDR_WIDTH register with synchronous active-low reset, increment enable, and parallel load. Load has priority over increment.
- The FSM and the INSTR/ROM_ADDR registers stay in fetch_unit.

## Test plan
- Reset release, ROM[0]=0x3A, EXEC_DONE at first EXEC cycle -> IR_CE high only in cycle 3 after release with INSTR=0x3A; PC=1 in EXEC; ROM_ADDR=1 next fetch.
- Sequential run from PC=0 over 4 instructions, immediate EXEC_DONE -> IR_CE pulses every 4 cycles; INSTR follows ROM[0..3].
- PC=0xFF with ADDR_WIDTH=8 -> after LOAD PC=0x00; next ROM_ADDR=0x00.
- EXEC_DONE with JUMP=1, JUMP_ADDR=0x40 -> PC=0x40, ROM_ADDR=0x40 two cycles later. Same with HALT=1 also -> HALTED=1, PC unchanged, no further IR_CE.
- Spurious EXEC_DONE/JUMP in FETCH or WAIT -> ignored, PC unchanged. EXEC held 10 cycles without EXEC_DONE -> no fetch, IR_CE stays 0.
- RST_N=0 during WAIT -> next edge IDLE, PC=0, IR_CE=0. From HALTED, reset -> normal fetch resumes from address 0.
